game_controller: RTL
====================

# game_controller

Match-level controller for the pong datapath. Consumes the ball position produced by the ball controller, detects goals, keeps both players' scores, and drives the 2-bit game `state` that gates the ball controller and pad logic. It also inserts a serve pause after each point and ends the match at a configurable winning score. It sits between the ball controller's `x_ball` output and every block that consumes `state` or scores, including the ball controller and the score/text renderer.

## Interface
Parameters:
- `WIN_SCORE`, 9: points that end the match; must be in 1..15.
- `SERVE_TICKS`, 60: `timing_tick` pulses spent in `POINT` before play resumes; must be in 1..255.
- `GOAL_MARGIN`, 8: edge distance, in pixels, that counts as a goal.

Ports:
- `clk` in 1: system clock; the block's single clock.
- `rst` in 1: asynchronous, active-high reset.
- `timing_tick` in 1: one-cycle frame-rate strobe, shared with the ball controller.
- `start_btn` in 1: debounced, single-cycle start request.
- `x_ball` in 11: ball left-edge x coordinate, in pixels.
- `state` out 2: current `game_state_t`.
- `score_left` out 4: left player score.
- `score_right` out 4: right player score.
- `winner` out 2: 0 = none, 1 = left, 2 = right.
- `goal_pulse` out 1: one-cycle strobe on every scored point.

## Operation
- States: `START`, `PLAY`, `POINT`, `GAME_OVER` (encoded 0..3).
- `START`:
  - Scores, `winner` and the serve counter are held at 0.
  - `start_btn` → `PLAY`.
- `PLAY`: goal conditions are sampled only when `timing_tick`=1.
  - Left goal: `x_ball <= GOAL_MARGIN`. Increment `score_right`.
  - Right goal: `x_ball >= HOR_PIXELS - BALL_SIZE - GOAL_MARGIN`. Increment `score_left`.
  - Both conditions cannot hold together. If both are somehow true, the left-goal condition takes priority.
  - After a goal: if the incremented score equals `WIN_SCORE`, go to `GAME_OVER` and set `winner`. Otherwise go to `POINT`.
  - `start_btn` is ignored.
- `POINT`:
  - The ball controller re-centres the ball because `state != PLAY`.
  - The serve counter increments on each `timing_tick`. When it reaches `SERVE_TICKS`, the counter clears and the state returns to `PLAY`.
  - `start_btn` is ignored.
- `GAME_OVER`:
  - Scores and `winner` are frozen.
  - `start_btn` → `START`, which clears scores and `winner`.
- Arithmetic and widths:
  - Scores are 4-bit and saturate at `WIN_SCORE`; they never wrap.
  - The serve counter is 8-bit.
  - Edge comparisons use 11-bit unsigned arithmetic.
- Exactly one point per exit: leaving `PLAY` on the same edge as the score update prevents double counting.

## Timing
- All outputs are registered. Reset values: `state`=`START`, both scores 0, `winner` 0, `goal_pulse` 0, serve counter 0.
- Goal latency: sampled on the edge where `timing_tick`=1. On that same edge the score increments, `state` changes and `goal_pulse` rises. `goal_pulse` is high for exactly one cycle.
- `start_btn` takes effect on the next edge: `state` updates one cycle after the pulse.
- `POINT` → `PLAY` occurs on the edge carrying the `SERVE_TICKS`-th tick counted in `POINT`. The tick on the entry edge is not counted.
- Reset asserted mid-operation forces all reset values immediately (asynchronous). Release is synchronous to `clk`.

## Configuration
- Macro: `SERVE_DELAY_EN`.
- Defined: `POINT` lasts `SERVE_TICKS` ticks, as described under Operation.
- Undefined:
  - `POINT` lasts exactly one clock cycle, then `PLAY`.
  - The serve counter is not instantiated.
  - `SERVE_TICKS` is unused.

## Structure
- `vga_pkg` provides:
  - `game_state_t` (enum, 2 bits: `START`, `PLAY`, `POINT`, `GAME_OVER`).
  - Existing `HOR_PIXELS` and `VER_PIXELS`.
  - A shared `BALL_SIZE`=15, so the ball controller and this block agree on the ball size.
- One sub-module, `serve_timer`:
  - Ports: `clk`, `rst`, `en`, `tick`, `done`.
  - 8-bit tick counter with terminal `done` pulse.
  - Compiled only under `SERVE_DELAY_EN`.

## Test plan
- Reset, then `start_btn` pulse → all outputs at reset values first; `state`=`PLAY` one cycle after the pulse.
- In `PLAY`, `x_ball`=8 with `timing_tick` → `score_right`=1, `goal_pulse` high 1 cycle, `state`=`POINT`. Then after 60 ticks → `PLAY`. `x_ball`=8 with no tick → no change.
- `x_ball`=1001 (`HOR_PIXELS`=1024) with tick → `score_left`+1. Hold `x_ball`=1001 across further ticks while in `POINT` → score unchanged.
- Drive 9 right-side goals → `state`=`GAME_OVER`, `winner`=1, `score_left`=9. Extra goal stimulus → no change. `start_btn` → `START` with scores 0.
- Assert `rst` in `POINT` with serve counter at 30 → immediate `START`. After release and `start_btn` → clean `PLAY`, scores 0.
- Build without `SERVE_DELAY_EN`: goal → `POINT` for exactly 1 cycle → `PLAY`.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared display geometry, ball size and game state encoding
package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
  localparam int BALL_SIZE  = 15;

  typedef enum logic [1:0] {
    START     = 2'd0,
    PLAY      = 2'd1,
    POINT     = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  localparam logic [1:0] WINNER_NONE  = 2'd0;
  localparam logic [1:0] WINNER_LEFT  = 2'd1;
  localparam logic [1:0] WINNER_RIGHT = 2'd2;

endpackage

// File: rtl/game_controller_serve_timer.sv
// rtl/game_controller_serve_timer.sv - serve pause tick counter (built only with SERVE_DELAY_EN)
`ifdef SERVE_DELAY_EN
module serve_timer #(
  parameter int TICKS = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic tick,
  output logic done
);

  localparam logic [7:0] LAST = 8'(TICKS - 1);

  logic [7:0] count;

  // done fires on the edge carrying the TICKS-th tick seen while enabled
  assign done = en && tick && (count == LAST);

  // count ticks while enabled; clear when idle or on the terminal tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (!en || done) begin
      count <= 8'd0;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/game_controller.sv
// rtl/game_controller.sv - pong match controller: goals, scores, serve pause, game over (option: SERVE_DELAY_EN)
module game_controller
  import vga_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 60,
  parameter int GOAL_MARGIN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        start_btn,
  input  logic [10:0] x_ball,
  output logic [1:0]  state,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic [1:0]  winner,
  output logic        goal_pulse
);

  localparam logic [10:0] LEFT_EDGE  = 11'(GOAL_MARGIN);
  localparam logic [10:0] RIGHT_EDGE = 11'(HOR_PIXELS - BALL_SIZE - GOAL_MARGIN);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  game_state_t state_q, state_d;
  logic [3:0]  score_left_d, score_right_d;
  logic [1:0]  winner_d;
  logic        goal_d;
  logic        left_goal, right_goal;
  logic        serve_done;

  // left goal wins if both edge tests were ever true together
  assign left_goal  = (x_ball <= LEFT_EDGE);
  assign right_goal = !left_goal && (x_ball >= RIGHT_EDGE);

`ifdef SERVE_DELAY_EN
  serve_timer #(
    .TICKS (SERVE_TICKS)
  ) u_serve_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == POINT),
    .tick (timing_tick),
    .done (serve_done)
  );
`else
  // without the serve pause POINT lasts a single cycle; any legal SERVE_TICKS is nonzero
  assign serve_done = (SERVE_TICKS != 0);
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= START;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, score updates and goal strobe
  always_comb begin
    state_d       = state_q;
    score_left_d  = score_left;
    score_right_d = score_right;
    winner_d      = winner;
    goal_d        = 1'b0;
    case (state_q)
      START: begin
        score_left_d  = 4'd0;
        score_right_d = 4'd0;
        winner_d      = WINNER_NONE;
        if (start_btn) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (timing_tick && left_goal) begin
          goal_d = 1'b1;
          if (score_right != WIN) begin
            score_right_d = score_right + 4'd1;
          end
          if (score_right_d == WIN) begin
            state_d  = GAME_OVER;
            winner_d = WINNER_RIGHT;
          end else begin
            state_d = POINT;
          end
        end else if (timing_tick && right_goal) begin
          goal_d = 1'b1;
          if (score_left != WIN) begin
            score_left_d = score_left + 4'd1;
          end
          if (score_left_d == WIN) begin
            state_d  = GAME_OVER;
            winner_d = WINNER_LEFT;
          end else begin
            state_d = POINT;
          end
        end
      end
      POINT: begin
        if (serve_done) begin
          state_d = PLAY;
        end
      end
      GAME_OVER: begin
        if (start_btn) begin
          state_d       = START;
          score_left_d  = 4'd0;
          score_right_d = 4'd0;
          winner_d      = WINNER_NONE;
        end
      end
      default: state_d = START;
    endcase
  end

  // registered scores, winner and goal strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_left  <= 4'd0;
      score_right <= 4'd0;
      winner      <= WINNER_NONE;
      goal_pulse  <= 1'b0;
    end else begin
      score_left  <= score_left_d;
      score_right <= score_right_d;
      winner      <= winner_d;
      goal_pulse  <= goal_d;
    end
  end

  assign state = state_q;

endmodule
